// File: rtl/wb_sram_pkg.sv
// Shared FSM encoding and default geometry for the Wishbone-to-SRAM bridge.
package wb_sram_pkg;
    localparam int WB_ADDR_WIDTH = 8;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_NUM_WMASKS = WB_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;
endpackage

// File: rtl/wb_sram_bridge.sv
// Wishbone slave driving a single-port synchronous SRAM (port 0).
// One access per request: ISSUE strobes the macro, WAIT covers read latency.
module wb_sram_bridge
    import wb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int NUM_WMASKS = WB_NUM_WMASKS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [NUM_WMASKS-1:0] wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [NUM_WMASKS-1:0] r_sel;
    logic                  r_we;
    logic                  w_req;
    logic                  w_unused_adr;

    assign w_req        = wbs_cyc_i & wbs_stb_i;
    // Byte offset and bits above the SRAM window are the decoder's business.
    assign w_unused_adr = &{wbs_adr_i[31:ADDR_WIDTH+2], wbs_adr_i[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_din   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_addr <= wbs_adr_i[ADDR_WIDTH+1:2];
                r_din  <= wbs_dat_i;
                r_sel  <= wbs_sel_i;
                r_we   <= wbs_we_i;
            end
            if (r_state == WAIT)
                r_rdata <= sram_dout0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                // A write with no byte lanes has nothing to do at the macro.
                if (w_req)
                    w_next = (wbs_we_i && wbs_sel_i == '0) ? ACK : ISSUE;
            end
            ISSUE:   w_next = r_we ? ACK : WAIT;
            WAIT:    w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // SRAM side decodes from registered state only.
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = r_sel;
        sram_addr0  = r_addr;
        sram_din0   = r_din;
        if (r_state == ISSUE) begin
            sram_csb0 = 1'b0;
            sram_web0 = ~r_we;
            if (!r_we)
                sram_wmask0 = '1;
        end
    end

    // Ack follows cyc so an abandoned cycle never sees a stale ack.
    assign wbs_ack_o = (r_state == ACK) & wbs_cyc_i;
    assign wbs_dat_o = r_rdata;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed bench for wb_sram_bridge with a behavioural SRAM model on port 0.
module tb_wb_sram_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;

    logic [31:0] mem [256];
    int          n_checks = 0;
    int          n_errors = 0;

    int          lat, icnt;
    logic        iweb;
    logic [7:0]  iaddr;
    logic [3:0]  imask;
    logic [31:0] idin;

    wb_sram_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    always #5 clk = ~clk;

    // Read data appears after the edge that samples csb0=0, stable for the next edge.
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
            end else begin
                sram_dout0 <= mem[sram_addr0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // One Wishbone transfer; latency counted in cycles from the sampling edge.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        lat = -1; icnt = 0; iweb = 1'bx; iaddr = 'x; imask = 'x; idin = 'x;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (!sram_csb0) begin
                icnt++; iweb = sram_web0; iaddr = sram_addr0;
                imask = sram_wmask0; idin = sram_din0;
            end
            if (wbs_ack_o) begin
                lat = c;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        sram_dout0 = '0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack",   {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_dat",   wbs_dat_o, 32'd0);
        chk("rst_csb",   {31'd0, sram_csb0}, 32'd1);
        chk("rst_web",   {31'd0, sram_web0}, 32'd1);
        chk("rst_mask",  {28'd0, sram_wmask0}, 32'd0);
        chk("rst_addr",  {24'd0, sram_addr0}, 32'd0);
        chk("rst_din",   sram_din0, 32'd0);
        rst_n = 1'b1;

        // Full-word write
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("wr_lat",   32'(lat), 32'd2);
        chk("wr_issue", 32'(icnt), 32'd1);
        chk("wr_web",   {31'd0, iweb}, 32'd0);
        chk("wr_addr",  {24'd0, iaddr}, 32'h04);
        chk("wr_mask",  {28'd0, imask}, 32'hF);
        chk("wr_din",   idin, 32'hDEADBEEF);
        chk("wr_mem",   mem[4], 32'hDEADBEEF);
        chk("wr_dato",  wbs_dat_o, 32'd0);

        // Read back
        xfer(1'b0, 32'h10, 32'h0, 4'hF);
        chk("rd_lat",   32'(lat), 32'd3);
        chk("rd_issue", 32'(icnt), 32'd1);
        chk("rd_web",   {31'd0, iweb}, 32'd1);
        chk("rd_mask",  {28'd0, imask}, 32'hF);
        chk("rd_data",  wbs_dat_o, 32'hDEADBEEF);

        // Single byte lane
        xfer(1'b1, 32'h10, 32'h0000AB00, 4'h2);
        chk("bw_lat",   32'(lat), 32'd2);
        chk("bw_mask",  {28'd0, imask}, 32'h2);
        xfer(1'b0, 32'h10, 32'h0, 4'hF);
        chk("bw_data",  wbs_dat_o, 32'hDEADABEF);

        // sel=0 write: no SRAM access, ack after one cycle, read data untouched
        xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
        chk("s0_lat",   32'(lat), 32'd1);
        chk("s0_issue", 32'(icnt), 32'd0);
        chk("s0_mem",   mem[8], 32'd0);
        chk("s0_dato",  wbs_dat_o, 32'hDEADABEF);

        // Upper and byte-offset address bits ignored: 0xFFFF0417 -> word 0x05
        xfer(1'b1, 32'hFFFF0417, 32'h12345678, 4'hF);
        chk("hi_addr",  {24'd0, iaddr}, 32'h05);
        xfer(1'b0, 32'h14, 32'h0, 4'hF);
        chk("hi_data",  wbs_dat_o, 32'h12345678);
        xfer(1'b0, 32'h10, 32'h0, 4'hF);
        chk("hi_back",  wbs_dat_o, 32'hDEADABEF);

        // Drop cyc during WAIT: read still completes, no ack
        @(negedge clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h14; wbs_sel_i = 4'hF;
        @(negedge clk);
        chk("dr_csb",   {31'd0, sram_csb0}, 32'd0);
        @(negedge clk);
        wbs_cyc_i = 0; wbs_stb_i = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("dr_noack", {31'd0, wbs_ack_o}, 32'd0);
        end
        chk("dr_data",  wbs_dat_o, 32'h12345678);
        xfer(1'b0, 32'h10, 32'h0, 4'hF);
        chk("dr_nxlat", 32'(lat), 32'd3);
        chk("dr_nxdat", wbs_dat_o, 32'hDEADABEF);

        // Reset during ISSUE abandons the write
        @(negedge clk);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h10;
        wbs_dat_i = 32'h55555555; wbs_sel_i = 4'hF;
        @(negedge clk);
        chk("rs_csb0",  {31'd0, sram_csb0}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_csb",   {31'd0, sram_csb0}, 32'd1);
        chk("rs_ack",   {31'd0, wbs_ack_o}, 32'd0);
        chk("rs_dat",   wbs_dat_o, 32'd0);
        @(negedge clk);
        wbs_cyc_i = 0; wbs_stb_i = 0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rs_noack", {31'd0, wbs_ack_o}, 32'd0);
        end
        chk("rs_dat2",  wbs_dat_o, 32'd0);
        chk("rs_mem",   mem[4], 32'hDEADABEF);
        xfer(1'b0, 32'h10, 32'h0, 4'hF);
        chk("rs_rdlat", 32'(lat), 32'd3);
        chk("rs_rddat", wbs_dat_o, 32'hDEADABEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
